// File: rtl/cm_word_packer.sv
// CM bus byte-to-word packer: assembles CLK_inter byte stream into 64-bit words
// and writes them into the ram1 buffer with a one-cycle strobe and fill status.

module cm_word_packer_chk #(
   parameter bit STOP_ON_FULL = 1'b1
) (
   input logic clk,
   input logic rst,
   input logic ram_wr_en,
   input logic frame_drop,
   input logic full
);

   // Writes are at least a word apart, so a strobe never lasts two cycles.
   a_strobe_single : assert property (@(posedge clk) disable iff (rst)
      ram_wr_en |=> !ram_wr_en);

   a_drop_no_write : assert property (@(posedge clk) disable iff (rst)
      !(ram_wr_en && frame_drop));

   a_full_only_stop : assert property (@(posedge clk) disable iff (rst)
      full |-> STOP_ON_FULL);

endmodule

module cm_word_packer #(
   parameter int BYTES_PER_WORD = 8,
   parameter int ADDR_W         = 4,
   parameter bit STOP_ON_FULL   = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [7:0]                  byte_in,
   input  logic                        byte_valid,
   input  logic                        frame_start,
   output logic [ADDR_W-1:0]           ram_addr,
   output logic [BYTES_PER_WORD*8-1:0] ram_data,
   output logic                        ram_wr_en,
   output logic [ADDR_W:0]             word_count,
   output logic [2:0]                  byte_idx,
   output logic                        full,
   output logic                        overflow,
   output logic                        frame_drop
);

   localparam int WORD_W = BYTES_PER_WORD * 8;
   localparam int DEPTH  = 2 ** ADDR_W;

   localparam logic [2:0]        LAST_IDX = 3'(BYTES_PER_WORD - 1);
   localparam logic [ADDR_W:0]   CNT_MAX  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_FULL    = 2'd2
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   logic [WORD_W-1:0]   shift_r;
   logic [WORD_W-1:0]   shift_nxt_s;
   logic [2:0]          byte_idx_r;
   logic [2:0]          idx_nxt_s;
   logic                wr_pulse_s;
   logic                drop_s;
   logic                ovf_set_s;

   logic [ADDR_W-1:0]   wr_ptr_r;
   logic [WORD_W-1:0]   ram_data_r;
   logic                ram_wr_en_r;
   logic [ADDR_W:0]     word_count_r;
   logic                full_r;
   logic                overflow_r;
   logic                frame_drop_r;

   // Next-state, byte assembly and event decode.
   always_comb begin
      state_nxt_s = state_r;
      shift_nxt_s = shift_r;
      idx_nxt_s   = byte_idx_r;
      wr_pulse_s  = 1'b0;
      drop_s      = 1'b0;
      ovf_set_s   = 1'b0;
      case (state_r)
         ST_IDLE, ST_COLLECT: begin
            if (frame_start) begin
               // Resync wins over a coincident byte 7: the partial word is dropped.
               drop_s = (byte_idx_r != 3'd0);
               if (byte_valid) begin
                  shift_nxt_s = {{(WORD_W - 8){1'b0}}, byte_in};
                  idx_nxt_s   = 3'd1;
                  state_nxt_s = ST_COLLECT;
               end else begin
                  shift_nxt_s = {WORD_W{1'b0}};
                  idx_nxt_s   = 3'd0;
                  state_nxt_s = ST_IDLE;
               end
            end else if (byte_valid) begin
               shift_nxt_s = {shift_r[WORD_W-9:0], byte_in};
               if (byte_idx_r == LAST_IDX) begin
                  idx_nxt_s  = 3'd0;
                  wr_pulse_s = 1'b1;
                  if (STOP_ON_FULL && (word_count_r == CNT_LAST)) begin
                     state_nxt_s = ST_FULL;
                  end else begin
                     state_nxt_s = ST_COLLECT;
                  end
               end else begin
                  idx_nxt_s   = byte_idx_r + 3'd1;
                  state_nxt_s = ST_COLLECT;
               end
            end else begin
               state_nxt_s = state_r;
            end
         end
         ST_FULL: begin
            ovf_set_s = byte_valid;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State, shift register and byte index.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         shift_r    <= {WORD_W{1'b0}};
         byte_idx_r <= 3'd0;
      end else begin
         state_r    <= state_nxt_s;
         shift_r    <= shift_nxt_s;
         byte_idx_r <= idx_nxt_s;
      end
   end

   // RAM write port: data/strobe on completion, pointer advances after the strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         ram_wr_en_r  <= 1'b0;
         ram_data_r   <= {WORD_W{1'b0}};
         wr_ptr_r     <= {ADDR_W{1'b0}};
         word_count_r <= {(ADDR_W + 1){1'b0}};
      end else begin
         ram_wr_en_r <= wr_pulse_s;
         if (wr_pulse_s) begin
            ram_data_r <= shift_nxt_s;
            if (word_count_r != CNT_MAX) begin
               word_count_r <= word_count_r + CNT_ONE;
            end
         end
         if (ram_wr_en_r) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
      end
   end

   // Status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         full_r       <= 1'b0;
         overflow_r   <= 1'b0;
         frame_drop_r <= 1'b0;
      end else begin
         full_r       <= (state_nxt_s == ST_FULL);
         overflow_r   <= overflow_r | ovf_set_s;
         frame_drop_r <= drop_s;
      end
   end

   // The strobe must drop in the very cycle rst is raised, hence the gate.
   assign ram_wr_en  = ram_wr_en_r & ~rst;
   assign ram_addr   = wr_ptr_r;
   assign ram_data   = ram_data_r;
   assign word_count = word_count_r;
   assign byte_idx   = byte_idx_r;
   assign full       = full_r;
   assign overflow   = overflow_r;
   assign frame_drop = frame_drop_r;

   cm_word_packer_chk #(
      .STOP_ON_FULL (STOP_ON_FULL)
   ) u_chk (
      .clk        (clk),
      .rst        (rst),
      .ram_wr_en  (ram_wr_en),
      .frame_drop (frame_drop),
      .full       (full)
   );

endmodule

// File: tb/tb_cm_word_packer.sv
// Bench for cm_word_packer: both STOP_ON_FULL variants driven in parallel and
// compared every cycle against a byte-counting reference model.
`timescale 1ns/1ps
module tb_cm_word_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  byte_in = 8'h00;
   logic        byte_valid = 1'b0;
   logic        frame_start = 1'b0;

   logic [3:0]  addr_a, addr_b;
   logic [63:0] data_a, data_b;
   logic        wr_a, wr_b;
   logic [4:0]  cnt_a, cnt_b;
   logic [2:0]  idx_a, idx_b;
   logic        full_a, full_b, ovf_a, ovf_b, drop_a, drop_b;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state, index 0 = stop on full, 1 = wrap
   logic [63:0] m_acc [2];
   logic [63:0] m_data [2];
   int          m_nb [2];
   int          m_cnt [2];
   int          m_ptr [2];
   bit          m_wr [2];
   bit          m_full [2];
   bit          m_ovf [2];
   bit          m_drop [2];

   always #5 clk = ~clk;

   cm_word_packer #(.BYTES_PER_WORD(8), .ADDR_W(4), .STOP_ON_FULL(1'b1)) dut_a (
      .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
      .frame_start(frame_start), .ram_addr(addr_a), .ram_data(data_a),
      .ram_wr_en(wr_a), .word_count(cnt_a), .byte_idx(idx_a), .full(full_a),
      .overflow(ovf_a), .frame_drop(drop_a));

   cm_word_packer #(.BYTES_PER_WORD(8), .ADDR_W(4), .STOP_ON_FULL(1'b0)) dut_b (
      .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
      .frame_start(frame_start), .ram_addr(addr_b), .ram_data(data_b),
      .ram_wr_en(wr_b), .word_count(cnt_b), .byte_idx(idx_b), .full(full_b),
      .overflow(ovf_b), .frame_drop(drop_b));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit bv, input logic [7:0] b, input bit fs);
      for (int c = 0; c < 2; c++) begin
         if (r) begin
            m_acc[c] = 64'd0; m_data[c] = 64'd0; m_nb[c] = 0; m_cnt[c] = 0;
            m_ptr[c] = 0; m_wr[c] = 1'b0; m_full[c] = 1'b0; m_ovf[c] = 1'b0;
            m_drop[c] = 1'b0;
         end else begin
            if (m_wr[c]) m_ptr[c] = (m_ptr[c] + 1) % 16;
            m_wr[c] = 1'b0;
            m_drop[c] = 1'b0;
            if (m_full[c]) begin
               if (bv) m_ovf[c] = 1'b1;
            end else if (fs) begin
               m_drop[c] = (m_nb[c] != 0);
               m_nb[c] = bv ? 1 : 0;
               m_acc[c] = bv ? 64'(b) : 64'd0;
            end else if (bv) begin
               m_acc[c] = m_acc[c] * 256 + 64'(b);
               m_nb[c]++;
               if (m_nb[c] == 8) begin
                  m_wr[c] = 1'b1;
                  m_data[c] = m_acc[c];
                  m_acc[c] = 64'd0;
                  m_nb[c] = 0;
                  if (m_cnt[c] < 16) m_cnt[c]++;
                  if (c == 0 && m_cnt[c] == 16) m_full[c] = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic compare_all();
      check("a.wr_en", 64'(wr_a), 64'(m_wr[0]));
      check("a.data", data_a, m_data[0]);
      check("a.addr", 64'(addr_a), 64'(m_ptr[0]));
      check("a.count", 64'(cnt_a), 64'(m_cnt[0]));
      check("a.idx", 64'(idx_a), 64'(m_nb[0]));
      check("a.full", 64'(full_a), 64'(m_full[0]));
      check("a.ovf", 64'(ovf_a), 64'(m_ovf[0]));
      check("a.drop", 64'(drop_a), 64'(m_drop[0]));
      check("b.wr_en", 64'(wr_b), 64'(m_wr[1]));
      check("b.data", data_b, m_data[1]);
      check("b.addr", 64'(addr_b), 64'(m_ptr[1]));
      check("b.count", 64'(cnt_b), 64'(m_cnt[1]));
      check("b.idx", 64'(idx_b), 64'(m_nb[1]));
      check("b.full", 64'(full_b), 64'(m_full[1]));
      check("b.ovf", 64'(ovf_b), 64'(m_ovf[1]));
      check("b.drop", 64'(drop_b), 64'(m_drop[1]));
   endtask

   // one clock: drive after negedge, model at posedge, compare at next negedge
   task automatic cyc(input bit r, input bit bv, input logic [7:0] b, input bit fs);
      rst = r; byte_valid = bv; byte_in = b; frame_start = fs;
      if (r) begin
         #1;
         check("rst_gate_a", 64'(wr_a), 64'd0);
         check("rst_gate_b", 64'(wr_b), 64'd0);
      end
      @(posedge clk);
      model_step(r, bv, b, fs);
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      @(negedge clk);
      do_reset();
      cyc(1'b0, 1'b0, 8'h00, 1'b0);

      // first word 01..08
      for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b1, 8'(i), 1'b0);
      check("w0_data", data_a, 64'h0102030405060708);
      check("w0_wr", 64'(wr_a), 64'd1);
      check("w0_addr", 64'(addr_a), 64'd0);
      check("w0_cnt", 64'(cnt_a), 64'd1);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);

      // fill buffer without gaps, then one more word
      do_reset();
      for (int i = 0; i < 136; i++) begin
         cyc(1'b0, 1'b1, 8'($urandom), 1'b0);
         if (i == 127) begin
            check("fill_full", 64'(full_a), 64'd1);
            check("fill_cnt", 64'(cnt_a), 64'd16);
         end
      end
      check("ovf_set", 64'(ovf_a), 64'd1);
      check("wrap_wr", 64'(wr_b), 64'd1);
      check("wrap_addr", 64'(addr_b), 64'd0);
      check("wrap_full", 64'(full_b), 64'd0);
      check("wrap_cnt", 64'(cnt_b), 64'd16);
      cyc(1'b0, 1'b1, 8'h55, 1'b1);

      // resync mid-word
      do_reset();
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'($urandom), 1'b0);
      cyc(1'b0, 1'b1, 8'hAA, 1'b1);
      check("resync_drop", 64'(drop_a), 64'd1);
      for (int i = 1; i <= 7; i++) cyc(1'b0, 1'b1, 8'(8'hB0 + i), 1'b0);
      check("resync_data", data_a, 64'hAAB1B2B3B4B5B6B7);
      check("resync_addr", 64'(addr_a), 64'd0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);

      // frame_start coincident with byte 7
      for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 8'($urandom), 1'b0);
      cyc(1'b0, 1'b1, 8'h77, 1'b1);
      check("fs_b7_nowr", 64'(wr_a), 64'd0);

      // toggling valid
      do_reset();
      for (int i = 0; i < 16; i++) cyc(1'b0, (i % 2) == 0, 8'(8'h10 + i), 1'b0);
      check("toggle_idx", 64'(idx_a), 64'd0);
      check("toggle_data", data_a, 64'h10121416181A1C1E);

      // rst on the strobe cycle of word 2
      do_reset();
      for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'($urandom), 1'b0);
      check("w2_strobe", 64'(wr_a), 64'd1);
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 8'($urandom), 1'b0);
      check("post_rst_addr", 64'(addr_a), 64'd0);

      // random traffic
      do_reset();
      for (int i = 0; i < 600; i++) begin
         cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
             8'($urandom), $urandom_range(0, 29) == 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/cm_word_packer.md
Name: cm_word_packer

Overview:
- Assembles the 8-bit chip-interconnect byte stream from the Xmega (CM bus) into 64-bit words.
- Writes each completed word into the 16-entry ram1 buffer: generates address, write data and a single-cycle write strobe.
- Sits between CM byte capture and ram1, replacing the free-running shift/counter write path.
- Provides fill status for the LED/SEG user interface.

Parameters:
- BYTES_PER_WORD, 8, bytes assembled per RAM word (output width is BYTES_PER_WORD*8).
- ADDR_W, 4, RAM address width; DEPTH = 2**ADDR_W words.
- STOP_ON_FULL, 1, 1 = halt and drop bytes when buffer full; 0 = wrap the write pointer and overwrite.

Ports:
- clk  input  1  sole clock, byte-sample clock (CLK_inter domain).
- rst  input  1  synchronous reset, active-high.
- byte_in  input  8  CM byte.
- byte_valid  input  1  byte_in is sampled on this clk edge when high.
- frame_start  input  1  resynchronise: discard partial word, next accepted byte is byte 0.
- ram_addr  output  ADDR_W  RAM write address (to ram1 addr).
- ram_data  output  64  assembled word (to ram1 data_in).
- ram_wr_en  output  1  one-cycle write strobe (to ram1 wr_en).
- word_count  output  ADDR_W+1  words written since reset, saturates at DEPTH.
- byte_idx  output  3  index of next byte within current word.
- full  output  1  DEPTH words written (STOP_ON_FULL=1 only).
- overflow  output  1  sticky: a byte was dropped while full.
- frame_drop  output  1  one-cycle pulse: frame_start discarded a non-empty partial word.

Behaviour:
- Reset: all outputs 0; shift register 0; write pointer 0; state IDLE.
- States: IDLE (no byte since reset/resync), COLLECT (partial word held), FULL.
  - IDLE -> COLLECT on the first accepted byte.
  - COLLECT -> IDLE on frame_start with no coincident byte.
  - COLLECT -> FULL on the write that makes word_count = DEPTH, when STOP_ON_FULL=1.
  - FULL is left only by rst.
- Byte accept: byte_valid=1 and state != FULL.
  - Shift register updates to {shift[55:0], byte_in}: the first byte lands in the MSB after 8 shifts.
  - byte_idx increments and wraps 7 -> 0.
- Word complete: accepting byte with byte_idx=7.
  - Next cycle: ram_data = assembled word, ram_addr = write pointer, ram_wr_en = 1 for exactly one cycle.
  - Write pointer increments in the cycle after the strobe; ram_addr updates with it.
  - Latency: last byte edge to strobe high = 1 clk.
  - ram_data holds the last written word until the next write.
- Back-to-back: byte_valid may stay high continuously. The strobe cycle of word N coincides with byte 0 of word N+1, with no stall. Minimum write spacing is 8 clks.
- word_count increments with each strobe and saturates at DEPTH. With STOP_ON_FULL=0 it saturates while the pointer wraps 15 -> 0, and full stays 0.
- FULL state:
  - byte_valid is ignored; overflow sets and stays set until rst.
  - No further ram_wr_en.
  - The final strobe still completes in the cycle of FULL entry.
- frame_start:
  - Clears byte_idx and the shift register.
  - frame_drop pulses the next cycle if byte_idx != 0.
  - A byte_valid coincident with frame_start is accepted as byte 0 of the new word (byte_idx becomes 1).
  - frame_start coincident with byte 7 wins: no write, and frame_drop pulses.
  - frame_start has no effect in FULL.
- rst mid-word or mid-strobe: the strobe is deasserted that cycle and the partial word is lost. RAM contents are not cleared.

Test Plan:
- Reset then 8 bytes 0x01..0x08 consecutive -> ram_wr_en=1 one clk after 8th edge, ram_data=0x0102030405060708, ram_addr=0, word_count=1.
- 128 consecutive bytes, no gaps -> 16 strobes spaced 8 clks, addrs 0..15, full=1 after 16th, word_count=16; 17th word bytes -> no strobe, overflow=1.
- STOP_ON_FULL=0, 136 bytes -> 17th strobe at ram_addr=0, full=0, word_count=16.
- 3 bytes, then frame_start with byte 0xAA, then 7 bytes 0xB1..0xB7 -> frame_drop pulse, word 0xAAB1B2B3B4B5B6B7 at addr 0.
- byte_valid toggling 1/0 every clk for 16 clks -> one strobe, word correct, byte_idx=0 after.
- rst asserted on the strobe cycle of word 2 -> ram_wr_en=0 that cycle, all outputs 0 next cycle, next word writes addr 0.
